// File: rtl/fano_metric_arbiter.sv
// fano_metric_arbiter
// Shares one fixed-latency branch-metric unit between N_REQ Fano decoder lanes.
// A round-robin grant picks at most one lane per cycle. The grant is issued to
// the unit on a registered strobe. The requester ID rides a tag pipeline so that
// the returned metric can be steered back to the lane that asked for it.
//
// Handshake: a lane holds req_valid and req_addr stable until it sees req_ready.
// A transfer happens in any cycle where req_valid & req_ready are both high for
// that lane. req_ready is combinational, one-hot, and never depends on the
// lane's own ready. A lane may drop req_valid before it is granted; the request
// is then simply never issued. Responses have no backpressure: a lane must
// accept rsp_valid whenever it appears.
module fano_metric_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int LAT    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        cfg_mask,
  input  logic                    flush,
  output logic                    unit_valid,
  output logic [ADDR_W-1:0]       unit_addr,
  input  logic [DATA_W-1:0]       unit_data,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    busy
);

  // Lane ID width; a single lane still gets a 1-bit ID.
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // Lane count at ID_W+1 bits, used for the modulo wrap of pointer sums.
  localparam logic [ID_W:0] N_REQ_W = (ID_W+1)'(N_REQ);

  // Round-robin pointer: the lane searched first in the next cycle.
  logic [ID_W-1:0]   ptr_q, ptr_d;

  // Shared-unit issue registers.
  logic              unit_valid_q, unit_valid_d;
  logic [ADDR_W-1:0] unit_addr_q, unit_addr_d;

  // Tag pipeline. Stage 0 lines up with unit_valid. Stage LAT lines up with the
  // cycle in which unit_data carries the result for that tag.
  logic [LAT:0]      tag_v_q, tag_v_d;
  logic [ID_W-1:0]   tag_id_q [LAT+1];
  logic [ID_W-1:0]   tag_id_d [LAT+1];

  // Response registers.
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              busy_q, busy_d;

  // Grant datapath.
  logic [N_REQ-1:0]   elig;
  logic [2*N_REQ-1:0] elig_dbl;
  logic [N_REQ-1:0]   elig_rot;
  logic               hit;
  logic [ID_W-1:0]    off;
  logic [ID_W:0]      gnt_sum;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_vld;
  logic [ID_W:0]      ptr_inc;
  logic [ADDR_W-1:0]  sel_addr;
  logic               rsp_fire;

  // Masked lanes are invisible to the arbiter in the same cycle.
  assign elig     = req_valid & cfg_mask;
  assign elig_dbl = {elig, elig};
  // Rotate so that bit 0 is the lane at ptr; the lowest set bit wins.
  assign elig_rot = N_REQ'(elig_dbl >> ptr_q);

  // Find the first eligible lane at or after ptr, modulo N_REQ.
  always_comb begin
    hit     = 1'b0;
    off     = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (elig_rot[j]) begin
        hit = 1'b1;
        off = ID_W'(j);
      end
    end
    gnt_sum = {1'b0, ptr_q} + {1'b0, off};
    if (gnt_sum >= N_REQ_W) begin
      gnt_sum = gnt_sum - N_REQ_W;
    end
    grant_idx = gnt_sum[ID_W-1:0];
    // Reset and flush both close the door on new requests.
    grant_vld = hit & rst_n & ~flush;
  end

  // One-hot ready to the granted lane, plus that lane's address.
  always_comb begin
    req_ready = '0;
    sel_addr  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        req_ready[i] = grant_vld;
        sel_addr     = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Advance the pointer past the granted lane; hold it when nothing is granted.
  always_comb begin
    ptr_inc = {1'b0, grant_idx} + 1'b1;
    if (ptr_inc == N_REQ_W) begin
      ptr_inc = '0;
    end
    ptr_d = grant_vld ? ptr_inc[ID_W-1:0] : ptr_q;
  end

  // Issue stage and tag shift register; flush empties every stage at once.
  always_comb begin
    unit_valid_d = grant_vld;
    unit_addr_d  = grant_vld ? sel_addr : unit_addr_q;
    tag_v_d[0]   = grant_vld;
    tag_id_d[0]  = grant_idx;
    for (int s = 1; s <= LAT; s++) begin
      tag_v_d[s]  = tag_v_q[s-1];
      tag_id_d[s] = tag_id_q[s-1];
    end
    if (flush) begin
      tag_v_d = '0;
    end
  end

  // Route the returning metric to its lane unless a flush kills it this cycle.
  always_comb begin
    rsp_fire    = tag_v_q[LAT] & ~flush;
    rsp_valid_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (tag_id_q[LAT] == ID_W'(i)) begin
        rsp_valid_d[i] = rsp_fire;
      end
    end
    rsp_data_d = rsp_fire ? unit_data : rsp_data_q;
    // busy reflects the pipeline contents being loaded at this edge.
    busy_d     = unit_valid_d | (|tag_v_d);
  end

  // State registers with synchronous active-low reset; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      unit_valid_q <= 1'b0;
      unit_addr_q  <= '0;
      tag_v_q      <= '0;
      for (int s = 0; s <= LAT; s++) begin
        tag_id_q[s] <= '0;
      end
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      unit_valid_q <= unit_valid_d;
      unit_addr_q  <= unit_addr_d;
      tag_v_q      <= tag_v_d;
      for (int s = 0; s <= LAT; s++) begin
        tag_id_q[s] <= tag_id_d[s];
      end
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      busy_q       <= busy_d;
    end
  end

  assign unit_valid = unit_valid_q;
  assign unit_addr  = unit_addr_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fano_metric_arbiter.sv
// Testbench for fano_metric_arbiter: directed scenarios followed by random
// traffic, checked against a cycle-level round-robin model with expected queues.
module tb_fano_metric_arbiter;

  localparam int N   = 4;
  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int LAT = 2;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    cfg_mask = '1;
  logic            flush = 1'b0;
  logic            unit_valid;
  logic [AW-1:0]   unit_addr;
  logic [DW-1:0]   unit_data = '0;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            busy;

  always #5 clk = ~clk;

  fano_metric_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .cfg_mask(cfg_mask), .flush(flush),
    .unit_valid(unit_valid), .unit_addr(unit_addr), .unit_data(unit_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  // {due cycle[31:0], lane[7:0], data[15:0]}
  logic [55:0]   exp_q[$];
  // {due cycle[31:0], addr[7:0]}
  logic [39:0]   unit_q[$];
  logic [N-1:0]  exp_ready = '0;
  logic          exp_busy = 1'b0;
  logic [DW-1:0] exp_last = '0;
  // Address seen by the emulated metric unit, keyed by the cycle its result is due.
  logic [AW-1:0] uaddr_at[int];

  // Reference model state.
  int            m_ptr = 0;
  logic [N-1:0]  m_mask = '1;
  logic [N-1:0]  lv = '0;
  logic [N-1:0]  hold_v = '0;
  logic [AW-1:0] la [N];
  logic [N-1:0]  granted_last = '0;
  bit            rand_mode = 1'b0;

  // The emulated metric unit's result for an address.
  function automatic logic [DW-1:0] fdat(input logic [AW-1:0] a);
    return {a ^ 8'hC3, ~a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: set lane inputs, then work out from the round-robin rule
  // what the DUT must grant, issue and answer.
  task automatic step(input bit fl, input bit rn);
    int g;
    int l;
    int due;
    logic [55:0] kq[$];
    logic [39:0] ku[$];
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (rand_mode) begin
        if (granted_last[i] || !lv[i]) begin
          lv[i] = 1'($urandom_range(1));
          la[i] = AW'($urandom_range(255));
        end else if ($urandom_range(15) == 0) begin
          lv[i] = 1'b0;
        end
      end else begin
        if (granted_last[i]) la[i] = AW'($urandom_range(255));
        lv[i] = hold_v[i];
      end
    end
    // busy in this cycle: any request granted earlier whose issue/tag window covers it
    exp_busy = 1'b0;
    foreach (exp_q[k]) begin
      due = int'(exp_q[k][55:24]);
      if (cyc >= due - LAT - 1 && cyc <= due - 1) exp_busy = 1'b1;
    end
    flush     = fl;
    rst_n     = rn;
    cfg_mask  = m_mask;
    req_valid = lv;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = la[i];
    unit_data = uaddr_at.exists(cyc) ? fdat(uaddr_at[cyc]) : DW'($urandom_range(65535));
    if (uaddr_at.exists(cyc)) uaddr_at.delete(cyc);
    granted_last = '0;
    exp_ready    = '0;
    if (!rn || fl) begin
      // Anything already on the outputs stays; everything later is lost.
      foreach (exp_q[k]) if (int'(exp_q[k][55:24]) <= cyc) kq.push_back(exp_q[k]);
      foreach (unit_q[k]) if (int'(unit_q[k][39:8]) <= cyc) ku.push_back(unit_q[k]);
      exp_q  = kq;
      unit_q = ku;
      if (!rn) m_ptr = 0;
    end else begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        l = (m_ptr + k) % N;
        if (g < 0 && lv[l] && m_mask[l]) g = l;
      end
      if (g >= 0) begin
        exp_ready       = N'(1) << g;
        granted_last[g] = 1'b1;
        m_ptr           = (g + 1) % N;
        unit_q.push_back({32'(cyc + 1), la[g]});
        exp_q.push_back({32'(cyc + LAT + 2), 8'(g), fdat(la[g])});
      end
    end
  endtask

  task automatic hold(input logic [N-1:0] v, input int n);
    hold_v = v;
    for (int i = 0; i < n; i++) step(1'b0, 1'b1);
  endtask

  // ---------------- monitor ----------------
  // Compares every DUT output mid-cycle and pops expectations as they fall due.
  always @(negedge clk) begin : monitor
    logic [55:0] e;
    logic [39:0] u;
    logic [31:0] oh;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("busy", 32'(busy), 32'(exp_busy));
    if (unit_q.size() > 0 && int'(unit_q[0][39:8]) == cyc) begin
      u = unit_q.pop_front();
      chk("unit_valid", 32'(unit_valid), 32'd1);
      chk("unit_addr", 32'(unit_addr), 32'(u[7:0]));
    end else begin
      chk("unit_valid_idle", 32'(unit_valid), 32'd0);
    end
    if (unit_valid === 1'b1) uaddr_at[cyc + LAT] = unit_addr;
    if (exp_q.size() > 0 && int'(exp_q[0][55:24]) == cyc) begin
      e  = exp_q.pop_front();
      oh = 32'd1 << e[23:16];
      chk("rsp_valid", 32'(rsp_valid), oh);
      chk("rsp_data", 32'(rsp_data), 32'(e[15:0]));
      exp_last = e[15:0];
    end else begin
      chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
      chk("rsp_data_hold", 32'(rsp_data), 32'(exp_last));
    end
    if (rst_n === 1'b0) exp_last = '0;
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < N; i++) la[i] = '0;
    // Reset
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    @(negedge clk);
    chk("unit_addr_reset", 32'(unit_addr), 32'd0);

    // Single request from lane 2, address 0x3C
    la[2] = 8'h3C;
    hold(4'b0100, 1);
    hold(4'b0000, 6);

    // All lanes valid for 8 cycles straight out of reset
    step(1'b0, 1'b0);
    hold(4'b1111, 8);
    hold(4'b0000, 6);

    // Fairness: park ptr at 3, then lanes 1 and 3 compete
    hold(4'b0100, 1);
    hold(4'b1010, 2);
    hold(4'b1111, 1);
    hold(4'b0000, 6);

    // Masking lane 1
    m_mask = 4'b1101;
    hold(4'b1111, 9);
    m_mask = 4'b1111;
    hold(4'b0000, 6);

    // Flush one cycle after lane 2's grant
    hold(4'b0001, 1);
    hold(4'b0010, 1);
    hold(4'b0100, 1);
    hold_v = 4'b0000;
    step(1'b1, 1'b1);
    hold(4'b0000, 6);

    // Reset mid-flight
    hold(4'b0010, 1);
    hold(4'b0000, 1);
    step(1'b0, 1'b0);
    hold(4'b1111, 1);
    hold(4'b0000, 6);

    // Random traffic with occasional flush, reset and mask changes
    rand_mode = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(31) == 0) m_mask = N'($urandom_range(15));
      step($urandom_range(63) == 0, $urandom_range(255) != 0);
    end

    // Drain
    rand_mode = 1'b0;
    m_mask    = '1;
    hold(4'b0000, LAT + 6);
    chk("drain_empty", 32'(exp_q.size() + unit_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
